// File: rtl/eth_pkg.sv
// Shared constants and types for the 10G receive datapath.
package eth_pkg;

    localparam int unsigned AXIS_DATA_W = 64;
    localparam int unsigned AXIS_KEEP_W = AXIS_DATA_W / 8;

    typedef struct packed {
        logic                   tlast;
        logic [AXIS_KEEP_W-1:0] tkeep;
        logic [AXIS_DATA_W-1:0] tdata;
    } axis_word_t;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_FRAME = 2'd1,
        WR_DROP  = 2'd2
    } wr_state_e;

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module eth_sdp_ram #(
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned WIDTH      = 73,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/eth_rx_pkt_fifo.sv
// Store-and-forward receive FIFO: frames are released only once complete and good;
// errored or overflowing frames are discarded whole.
module eth_rx_pkt_fifo
    import eth_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned C_DATA_WIDTH = AXIS_DATA_W,
    parameter int unsigned KEEP_WIDTH   = C_DATA_WIDTH / 8
) (
    input  logic                    clk156,
    input  logic                    eth_rst_n,
    input  logic                    s_axis_tvalid,
    input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tuser,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    output logic [31:0]             good_cnt,
    output logic [31:0]             bad_cnt,
    output logic [31:0]             ovf_cnt
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned PTR_W  = ADDR_WIDTH + 1;
    localparam int unsigned WORD_W = C_DATA_WIDTH + KEEP_WIDTH + 1;
    localparam logic [PTR_W-1:0] FULL_LVL = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    wr_state_e         state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  commit_ptr_q, commit_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  fetch_ptr_q;
    logic [31:0]       good_q, good_d, bad_q, bad_d, ovf_q, ovf_d;
    logic              wr_en;
    logic              full;

    logic              ram_valid_q, out_valid_q;
    logic [WORD_W-1:0] out_word_q;
    logic [WORD_W-1:0] ram_rdata;
    logic              ram_re, out_load, out_xfer;

    // rd_ptr tracks consumed beats, so prefetched-but-unsent beats still occupy space.
    assign full = (wr_ptr_q - rd_ptr_q) == FULL_LVL;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        good_d       = good_q;
        bad_d        = bad_q;
        ovf_d        = ovf_q;
        wr_en        = 1'b0;
        if (s_axis_tvalid) begin
            case (state_q)
                WR_IDLE, WR_FRAME: begin
                    if (full) begin
                        wr_ptr_d = commit_ptr_q;
                        if (s_axis_tlast) begin
                            ovf_d   = ovf_q + 32'd1;
                            state_d = WR_IDLE;
                        end else begin
                            state_d = WR_DROP;
                        end
                    end else if (!s_axis_tlast) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        state_d  = WR_FRAME;
                    end else if (!s_axis_tuser) begin
                        wr_en        = 1'b1;
                        wr_ptr_d     = wr_ptr_q + PTR_ONE;
                        commit_ptr_d = wr_ptr_q + PTR_ONE;
                        good_d       = good_q + 32'd1;
                        state_d      = WR_IDLE;
                    end else begin
                        wr_ptr_d = commit_ptr_q;
                        bad_d    = bad_q + 32'd1;
                        state_d  = WR_IDLE;
                    end
                end
                WR_DROP: begin
                    if (s_axis_tlast) begin
                        ovf_d   = ovf_q + 32'd1;
                        state_d = WR_IDLE;
                    end
                end
                default: state_d = WR_IDLE;
            endcase
        end
    end

    // Two-stage prefetch: RAM read register feeds the output register.
    assign out_xfer = out_valid_q && m_axis_tready;
    assign out_load = ram_valid_q && (!out_valid_q || m_axis_tready);
    assign ram_re   = (fetch_ptr_q != commit_ptr_q) && (!ram_valid_q || out_load);

    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            state_q      <= WR_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            fetch_ptr_q  <= '0;
            good_q       <= '0;
            bad_q        <= '0;
            ovf_q        <= '0;
            ram_valid_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            good_q       <= good_d;
            bad_q        <= bad_d;
            ovf_q        <= ovf_d;
            if (ram_re) begin
                fetch_ptr_q <= fetch_ptr_q + PTR_ONE;
            end
            if (out_xfer) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (ram_re) begin
                ram_valid_q <= 1'b1;
            end else if (out_load) begin
                ram_valid_q <= 1'b0;
            end
            if (out_load) begin
                out_valid_q <= 1'b1;
                out_word_q  <= ram_rdata;
            end else if (out_xfer) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    eth_sdp_ram #(
        .DEPTH      (DEPTH),
        .WIDTH      (WORD_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk156),
        .we    (wr_en),
        .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
        .re    (ram_re),
        .raddr (fetch_ptr_q[ADDR_WIDTH-1:0]),
        .rdata (ram_rdata)
    );

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_word_q[C_DATA_WIDTH-1:0];
    assign m_axis_tkeep  = out_word_q[C_DATA_WIDTH +: KEEP_WIDTH];
    assign m_axis_tlast  = out_word_q[WORD_W-1];
    assign m_axis_tuser  = 1'b0;
    assign good_cnt      = good_q;
    assign bad_cnt       = bad_q;
    assign ovf_cnt       = ovf_q;

endmodule
